// File: rtl/gain_ramp_amplifier.sv
// Gain ramp and sample scaler: slews the applied gain toward the FSK/PSK target in
// fixed steps, and multiplies carrier samples by it through a 2-stage pipeline.
module gain_ramp_amplifier #(
    parameter int SAMPLE_W   = 12,
    parameter int GAIN_W     = 9,
    parameter int GAIN_SHIFT = 8,
    parameter int RAMP_STEP  = 8,
    parameter int RAMP_DIV   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [GAIN_W-1:0]   scaled_gain_fsk,
    input  logic [GAIN_W-1:0]   scaled_gain_psk,
    input  logic                mod_sel,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_valid,
    output logic [GAIN_W-1:0]   gain_cur,
    output logic                ramp_busy
);

    localparam int PROD_W = SAMPLE_W + GAIN_W;
    localparam int CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0]          TICK_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [GAIN_W-1:0]         STEP      = GAIN_W'(RAMP_STEP);
    localparam logic signed [PROD_W-1:0]  SAT_HI    = PROD_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0]  SAT_LO    = ~SAT_HI;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     tick_cnt_q;
    logic [GAIN_W-1:0]    gain_cur_q;
    logic                 ramp_busy_q;
    logic [GAIN_W-1:0]    target_q;
    logic [GAIN_W-1:0]    target_d;
    logic [GAIN_W-1:0]    gain_diff;
    logic [GAIN_W-1:0]    gain_next_d;

    logic signed [SAMPLE_W-1:0] sample_in_s;
    logic signed [PROD_W-1:0]   prod_p1_d;
    logic signed [PROD_W-1:0]   prod_p1_q;
    logic                       vld_p1_q;
    logic signed [PROD_W-1:0]   shifted_p2;
    logic signed [SAMPLE_W-1:0] sample_p2_d;
    logic signed [SAMPLE_W-1:0] sample_p2_q;
    logic                       vld_p2_q;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[SAMPLE_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[SAMPLE_W-1:0];
        else
            return v[SAMPLE_W-1:0];
    endfunction

    // Step is clamped to the remaining distance, so the gain can neither overshoot nor wrap.
    always_comb begin
        target_d    = mod_sel ? scaled_gain_psk : scaled_gain_fsk;
        gain_diff   = '0;
        gain_next_d = gain_cur_q;
        if (target_q > gain_cur_q) begin
            gain_diff   = target_q - gain_cur_q;
            gain_next_d = gain_cur_q + ((gain_diff > STEP) ? STEP : gain_diff);
        end else begin
            gain_diff   = gain_cur_q - target_q;
            gain_next_d = gain_cur_q - ((gain_diff > STEP) ? STEP : gain_diff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            gain_cur_q  <= '0;
            ramp_busy_q <= 1'b0;
            target_q    <= '0;
        end else begin
            target_q <= target_d;
            case (state_q)
                IDLE: begin
                    tick_cnt_q  <= '0;
                    ramp_busy_q <= 1'b0;
                    if (target_q != gain_cur_q) begin
                        state_q     <= RAMP;
                        ramp_busy_q <= 1'b1;
                    end
                end
                RAMP: begin
                    if (target_q == gain_cur_q) begin
                        state_q     <= IDLE;
                        tick_cnt_q  <= '0;
                        ramp_busy_q <= 1'b0;
                    end else if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        gain_cur_q <= gain_next_d;
                        // Drop busy on the same edge the gain lands on its target.
                        if (gain_next_d == target_q) begin
                            state_q     <= IDLE;
                            ramp_busy_q <= 1'b0;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    tick_cnt_q  <= '0;
                    ramp_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: signed sample times zero-extended gain.
    always_comb begin
        sample_in_s = sample_in;
        prod_p1_d   = sample_in_s * $signed({1'b0, gain_cur_q});
    end

    // Stage p2: floor shift back to sample scale, then clamp.
    always_comb begin
        shifted_p2  = prod_p1_q >>> GAIN_SHIFT;
        sample_p2_d = saturate(shifted_p2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1_q   <= '0;
            vld_p1_q    <= 1'b0;
            sample_p2_q <= '0;
            vld_p2_q    <= 1'b0;
        end else begin
            prod_p1_q   <= prod_p1_d;
            vld_p1_q    <= sample_valid;
            sample_p2_q <= sample_p2_d;
            vld_p2_q    <= vld_p1_q;
        end
    end

    assign sample_out = sample_p2_q;
    assign out_valid  = vld_p2_q;
    assign gain_cur   = gain_cur_q;
    assign ramp_busy  = ramp_busy_q;

endmodule

// File: tb/tb_gain_ramp_amplifier.sv
// Directed bench for gain_ramp_amplifier: ramp timing, pipeline latency,
// saturation, floor rounding, reversal, mode switch and mid-ramp reset.
module tb_gain_ramp_amplifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  scaled_gain_fsk;
    logic [8:0]  scaled_gain_psk;
    logic        mod_sel;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [11:0] sample_out;
    logic        out_valid;
    logic [8:0]  gain_cur;
    logic        ramp_busy;

    int n_vec = 0;
    int n_bad = 0;

    gain_ramp_amplifier dut (
        .clk             (clk),
        .rst             (rst),
        .scaled_gain_fsk (scaled_gain_fsk),
        .scaled_gain_psk (scaled_gain_psk),
        .mod_sel         (mod_sel),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .sample_out      (sample_out),
        .out_valid       (out_valid),
        .gain_cur        (gain_cur),
        .ramp_busy       (ramp_busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_vec(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic v);
        sample_in    = s[11:0];
        sample_valid = v;
    endtask

    task automatic settle();
        int n;
        n = 0;
        step(3);
        while (ramp_busy === 1'b1 && n < 2000) begin
            step(1);
            n++;
        end
        check_vec("settle", ramp_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scaled_gain_fsk = 9'd256;
        scaled_gain_psk = 9'd0;
        mod_sel         = 1'b0;
        drive(0, 1'b0);
        rst = 1'b1;
        step(3);
        check_vec("rst_gain", gain_cur, 0);
        check_vec("rst_busy", ramp_busy, 0);
        check_vec("rst_valid", out_valid, 0);
        check_vec("rst_out", $signed(sample_out), 0);

        // Ramp 0 -> 256 after reset release
        rst = 1'b0;
        step(1);
        check_vec("busy_e1", ramp_busy, 0);
        step(1);
        check_vec("busy_e2", ramp_busy, 1);
        check_vec("gain_start", gain_cur, 0);
        for (int k = 1; k <= 32; k++) begin
            step(4);
            check_vec("ramp_up", gain_cur, 8 * k);
        end
        check_vec("busy_done", ramp_busy, 0);

        // Unity gain, latency 2
        drive(1000, 1'b1);
        step(1);
        drive(0, 1'b0);
        check_vec("lat1_valid", out_valid, 0);
        step(1);
        check_vec("unity_out", $signed(sample_out), 1000);
        check_vec("unity_valid", out_valid, 1);

        // Back-to-back samples
        drive(1, 1'b1);
        step(1);
        drive(2, 1'b1);
        step(1);
        check_vec("b2b_1", $signed(sample_out), 1);
        drive(3, 1'b1);
        step(1);
        check_vec("b2b_2", $signed(sample_out), 2);
        drive(0, 1'b0);
        step(1);
        check_vec("b2b_3", $signed(sample_out), 3);
        check_vec("b2b_3_valid", out_valid, 1);
        step(1);
        check_vec("b2b_end_valid", out_valid, 0);

        // Gain 511, saturation
        scaled_gain_fsk = 9'd511;
        settle();
        check_vec("gain_511", gain_cur, 511);
        drive(1000, 1'b1);
        step(1);
        drive(2047, 1'b1);
        step(1);
        check_vec("g511_1000", $signed(sample_out), 1996);
        drive(-2048, 1'b1);
        step(1);
        check_vec("g511_sat_hi", $signed(sample_out), 2047);
        drive(0, 1'b1);
        step(1);
        check_vec("g511_sat_lo", $signed(sample_out), -2048);
        drive(0, 1'b0);
        step(1);
        check_vec("g511_zero", $signed(sample_out), 0);
        check_vec("g511_zero_valid", out_valid, 1);

        // Gain 1, floor rounding
        scaled_gain_fsk = 9'd0;
        settle();
        check_vec("gain_0", gain_cur, 0);
        scaled_gain_fsk = 9'd1;
        settle();
        check_vec("gain_1", gain_cur, 1);
        drive(-1, 1'b1);
        step(1);
        drive(1000, 1'b1);
        step(1);
        check_vec("g1_floor_neg", $signed(sample_out), -1);
        drive(0, 1'b0);
        step(1);
        check_vec("g1_1000", $signed(sample_out), 3);

        // Ramp to a non-multiple of the step
        scaled_gain_fsk = 9'd0;
        settle();
        scaled_gain_fsk = 9'd100;
        step(2);
        check_vec("nm_busy", ramp_busy, 1);
        for (int k = 1; k <= 13; k++) begin
            step(4);
            check_vec("nm_ramp", gain_cur, (8 * k > 100) ? 100 : 8 * k);
        end
        check_vec("nm_idle", ramp_busy, 0);

        // Mid-ramp reversal, then mode switch
        scaled_gain_fsk = 9'd0;
        settle();
        scaled_gain_fsk = 9'd256;
        step(2);
        check_vec("rev_busy", ramp_busy, 1);
        for (int k = 1; k <= 8; k++) begin
            step(4);
            check_vec("rev_up", gain_cur, 8 * k);
        end
        scaled_gain_fsk = 9'd40;
        for (int k = 1; k <= 3; k++) begin
            step(4);
            check_vec("rev_down", gain_cur, 64 - 8 * k);
        end
        check_vec("rev_idle", ramp_busy, 0);
        scaled_gain_psk = 9'd200;
        mod_sel         = 1'b1;
        step(2);
        check_vec("psk_busy", ramp_busy, 1);
        for (int k = 1; k <= 20; k++) begin
            step(4);
            check_vec("psk_ramp", gain_cur, 40 + 8 * k);
        end
        check_vec("psk_idle", ramp_busy, 0);

        // Reset mid-ramp with a sample in flight
        scaled_gain_psk = 9'd0;
        step(2);
        step(8);
        check_vec("pre_rst_gain", gain_cur, 184);
        drive(1000, 1'b1);
        step(1);
        rst = 1'b1;
        step(1);
        check_vec("mid_rst_gain", gain_cur, 0);
        check_vec("mid_rst_valid", out_valid, 0);
        check_vec("mid_rst_out", $signed(sample_out), 0);
        check_vec("mid_rst_busy", ramp_busy, 0);
        drive(0, 1'b0);
        scaled_gain_psk = 9'd200;
        rst = 1'b0;
        step(2);
        check_vec("restart_busy", ramp_busy, 1);
        step(4);
        check_vec("restart_gain", gain_cur, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
